pipe_in_block_fifo: RTL and testbench

//   Block-throttled receive buffer between the host Pipe In endpoint and the

---
 rtl/pipe_in_block_fifo.sv | 118 +++++++++++
 tb/tb_pipe_in_block_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_in_block_fifo.sv
// pipe_in_block_fifo
//   Receive buffer between the host Pipe In endpoint and the pipe-in data
//   checker. Endpoint words go into a first-word-fall-through FIFO. They are
//   drained to the checker over a valid/ready handshake. The endpoint ready
//   flag is raised only while a whole block of free space is available.
//
// Ports
//   clk          in   rising-edge clock for all logic
//   reset_n      in   asynchronous active-low reset
//   flush        in   synchronous clear of FIFO, counters and flags
//   ep_write     in   endpoint write strobe, one word per cycle
//   ep_data      in   endpoint write data [WIDTH]
//   ep_ready     out  registered: at least BLOCK_WORDS free entries
//   dout_valid   out  dout_data holds the oldest stored word
//   dout_data    out  head-of-FIFO word [WIDTH]
//   dout_ready   in   consumer takes the word this cycle
//   level        out  words stored, 0..DEPTH [AW+1]
//   overflow     out  sticky, set when a write was dropped
//   block_count  out  completed blocks accepted, wraps at 2^32
//
// Handshake semantics:
//   Output side: a word transfers on every rising edge where dout_valid and
//   dout_ready are both high. dout_valid depends only on stored state, never
//   on dout_ready.
//   Input side: ep_write is accepted when the FIFO is not full, or when it is
//   full but a read happens in the same cycle. Otherwise the word is dropped
//   and overflow is set. ep_ready is advisory block-level flow control and
//   does not gate acceptance.
module pipe_in_block_fifo #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int BLOCK_WORDS = 256,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             ep_write,
  input  logic [WIDTH-1:0] ep_data,
  output logic             ep_ready,
  output logic             dout_valid,
  output logic [WIDTH-1:0] dout_data,
  input  logic             dout_ready,
  output logic [AW:0]      level,
  output logic             overflow,
  output logic [31:0]      block_count
);

  localparam logic [AW:0]   DEPTH_L    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   BLOCK_L    = (AW+1)'(BLOCK_WORDS);
  localparam logic [AW:0]   BLK_LAST_L = (AW+1)'(BLOCK_WORDS - 1);
  localparam logic [AW:0]   ONE_L      = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      blk_cnt;
  logic [AW:0]      level_next;
  logic             full;
  logic             rd;
  logic             wr;

  assign dout_valid = (level != '0);
  assign dout_data  = mem[rd_ptr];
  assign full       = (level == DEPTH_L);
  assign rd         = dout_valid & dout_ready;
  // When the FIFO is full, a simultaneous read frees the slot this write uses.
  assign wr         = ep_write & (~full | rd);

  always_comb begin
    level_next = level;
    if (wr && !rd)      level_next = level + ONE_L;
    else if (rd && !wr) level_next = level - ONE_L;
  end

  // Storage is not reset. Only the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (wr && !flush) mem[wr_ptr] <= ep_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      blk_cnt     <= '0;
      block_count <= '0;
      overflow    <= 1'b0;
      ep_ready    <= 1'b0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      blk_cnt     <= '0;
      block_count <= '0;
      overflow    <= 1'b0;
      ep_ready    <= (BLOCK_WORDS <= DEPTH);
    end else begin
      if (wr) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd) rd_ptr <= rd_ptr + PTR_ONE;
      level <= level_next;
      if (ep_write && full && !rd) overflow <= 1'b1;
      // Free space is judged on the updated level, so ep_ready drops on the
      // edge that commits the write which leaves less than one block free.
      ep_ready <= ((DEPTH_L - level_next) >= BLOCK_L);
      if (wr) begin
        if (blk_cnt == BLK_LAST_L) begin
          blk_cnt     <= '0;
          block_count <= block_count + 32'd1;
        end else begin
          blk_cnt <= blk_cnt + ONE_L;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipe_in_block_fifo.sv
module tb_pipe_in_block_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int BLOCK_WORDS = 4;
  localparam int AW = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             flush = 1'b0;
  logic             ep_write = 1'b0;
  logic [WIDTH-1:0] ep_data = '0;
  logic             ep_ready;
  logic             dout_valid;
  logic [WIDTH-1:0] dout_data;
  logic             dout_ready = 1'b0;
  logic [AW:0]      level;
  logic             overflow;
  logic [31:0]      block_count;

  logic [WIDTH-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  pipe_in_block_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .BLOCK_WORDS(BLOCK_WORDS)
  ) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .ep_write(ep_write), .ep_data(ep_data), .ep_ready(ep_ready),
    .dout_valid(dout_valid), .dout_data(dout_data), .dout_ready(dout_ready),
    .level(level), .overflow(overflow), .block_count(block_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: a read commits at the next rising edge whenever valid and ready
  // are both high (unless flush or reset wins), so sample at the falling edge.
  always @(negedge clk) begin
    if (reset_n && !flush && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check("rd_unexpected", dout_data, 32'hFFFF_FFFF);
      end else begin
        check("rd_data", dout_data, exp_q.pop_front());
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One endpoint write cycle; the caller says whether the word is accepted.
  task automatic write_word(input logic [31:0] d, input bit rd_en, input bit accept);
    ep_write = 1'b1;
    ep_data = d;
    dout_ready = rd_en;
    if (accept) exp_q.push_back(d);
    step();
    ep_write = 1'b0;
  endtask

  task automatic drain(input int n);
    dout_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
    dout_ready = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    exp_q.delete();
    step();
    flush = 1'b0;
  endtask

  initial begin
    // Reset release, no traffic
    repeat (3) step();
    reset_n = 1'b1;
    check("rst_ep_ready", 32'(ep_ready), 0);
    check("rst_level", 32'(level), 0);
    check("rst_dout_valid", 32'(dout_valid), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_block_count", block_count, 0);
    step();
    check("first_edge_ep_ready", 32'(ep_ready), 1);

    // One block with the consumer stalled, then drained in order
    for (int i = 1; i <= 4; i++) write_word(32'(i), 1'b0, 1'b1);
    check("blk1_level", 32'(level), 4);
    check("blk1_block_count", block_count, 1);
    check("blk1_dout_valid", 32'(dout_valid), 1);
    check("blk1_head", dout_data, 32'h1);
    check("blk1_ep_ready", 32'(ep_ready), 1);
    drain(4);
    check("blk1_drained_level", 32'(level), 0);
    check("blk1_drained_valid", 32'(dout_valid), 0);

    // Fill to 13: ep_ready falls after the 13th write, rises after one read
    for (int i = 0; i < 12; i++) write_word(32'h100 + 32'(i), 1'b0, 1'b1);
    check("fill12_ep_ready", 32'(ep_ready), 1);
    write_word(32'h10C, 1'b0, 1'b1);
    check("fill13_ep_ready", 32'(ep_ready), 0);
    check("fill13_level", 32'(level), 13);
    check("fill13_block_count", block_count, 4);
    drain(1);
    check("read1_ep_ready", 32'(ep_ready), 1);
    check("read1_level", 32'(level), 12);

    // Fill to 16, drop one write, then write+read while full
    for (int i = 0; i < 4; i++) write_word(32'h200 + 32'(i), 1'b0, 1'b1);
    check("full_level", 32'(level), 16);
    check("full_ep_ready", 32'(ep_ready), 0);
    check("full_block_count", block_count, 5);
    check("full_no_overflow", 32'(overflow), 0);
    write_word(32'hDEAD, 1'b0, 1'b0);
    check("drop_overflow", 32'(overflow), 1);
    check("drop_level", 32'(level), 16);
    check("drop_block_count", block_count, 5);
    write_word(32'hBEEF, 1'b1, 1'b1);
    dout_ready = 1'b0;
    check("full_wr_rd_level", 32'(level), 16);
    drain(16);
    check("full_drained_level", 32'(level), 0);
    check("full_drained_ep_ready", 32'(ep_ready), 1);
    check("overflow_sticky", 32'(overflow), 1);

    // Flush clears counters and the sticky flag
    do_flush();
    check("flush_overflow", 32'(overflow), 0);
    check("flush_block_count", block_count, 0);
    check("flush_ep_ready", 32'(ep_ready), 1);
    check("flush_level", 32'(level), 0);

    // Streaming: 18 words at equal read and write rate, pointers wrap
    for (int i = 0; i < 18; i++) write_word(32'h300 + 32'(i), 1'b1, 1'b1);
    check("stream_level", 32'(level), 1);
    drain(1);
    check("stream_drained_level", 32'(level), 0);
    check("stream_block_count", block_count, 4);
    // In-block count is 2, so two more words complete the fifth block
    write_word(32'h400, 1'b0, 1'b1);
    check("stream_partial_bc", block_count, 4);
    write_word(32'h401, 1'b0, 1'b1);
    check("stream_complete_bc", block_count, 5);
    drain(2);

    // Partial block then flush
    write_word(32'h500, 1'b0, 1'b1);
    write_word(32'h501, 1'b0, 1'b1);
    check("partial_bc", block_count, 5);
    check("partial_level", 32'(level), 2);
    do_flush();
    check("pflush_level", 32'(level), 0);
    check("pflush_valid", 32'(dout_valid), 0);
    check("pflush_overflow", 32'(overflow), 0);
    check("pflush_bc", block_count, 0);

    // Asynchronous reset in the middle of a block
    for (int i = 0; i < 3; i++) write_word(32'h600 + 32'(i), 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    check("arst_level", 32'(level), 0);
    check("arst_valid", 32'(dout_valid), 0);
    check("arst_ep_ready", 32'(ep_ready), 0);
    step();
    reset_n = 1'b1;
    step();
    check("arst_rel_ep_ready", 32'(ep_ready), 1);
    // The discarded partial block must not count toward the next one
    for (int i = 0; i < 3; i++) write_word(32'h700 + 32'(i), 1'b0, 1'b1);
    check("arst_bc_3", block_count, 0);
    write_word(32'h703, 1'b0, 1'b1);
    check("arst_bc_4", block_count, 1);
    drain(4);
    check("final_level", 32'(level), 0);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
